// File: rtl/tc_sram_bank_ctrl_if.sv
// Request/response channel between a bus bridge and the banked SRAM controller.
// The controller is the slave; init_done travels with the channel so masters can gate traffic.
interface tc_sram_bank_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
);
  localparam int MASK_W = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_wren;
  logic [MASK_W-1:0] req_mask;
  logic [DATA_W-1:0] req_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_wren;
  logic [DATA_W-1:0] rsp_data;
  logic              init_done;

  modport master (
    output req_valid, req_addr, req_wren, req_mask, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_wren, rsp_data, init_done
  );

  modport slave (
    input  req_valid, req_addr, req_wren, req_mask, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_wren, rsp_data, init_done
  );
endinterface

// File: rtl/tc_sram_bank_ctrl.sv
// Byte-maskable single-port SRAM built from word-interleaved banks, with a one-deep
// registered response stage and a post-reset fill of every word with INIT_VAL.
module tc_sram_bank_ctrl #(
  parameter int              DATA_W   = 32,
  parameter int              ADDR_W   = 12,
  parameter int              BANK_NUM = 4,
  parameter bit              INIT_EN  = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  tc_sram_bank_ctrl_if.slave bus
);
  localparam int MASK_W = DATA_W / 8;
  localparam int BANK_W = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 0;
  localparam int SEL_W  = (BANK_W > 0) ? BANK_W : 1;
  localparam int ROW_W  = ADDR_W - BANK_W;
  localparam int ROWS   = 2 ** ROW_W;
  localparam logic [ROW_W-1:0] LAST_ROW = '1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t             state, state_next;
  logic [ROW_W-1:0]   cnt, cnt_next;
  logic               init_done, init_done_next;
  logic               rsp_valid, rsp_wren;
  logic [SEL_W-1:0]   rsp_bank;
  logic [SEL_W-1:0]   bank_sel;
  logic [ROW_W-1:0]   row;
  logic               accept;
  logic [DATA_W-1:0]  rd_all [2**SEL_W];

  generate
    if (BANK_W > 0) begin : g_sel
      assign bank_sel = bus.req_addr[BANK_W-1:0];
      assign row      = bus.req_addr[ADDR_W-1:BANK_W];
    end else begin : g_nosel
      assign bank_sel = '0;
      assign row      = bus.req_addr;
    end
  endgenerate

  assign bus.req_ready = init_done & (~rsp_valid | bus.rsp_ready);
  assign accept        = bus.req_valid & bus.req_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= INIT_EN ? ST_INIT : ST_RUN;
      cnt       <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      init_done <= init_done_next;
    end
  end

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    init_done_next = init_done;
    case (state)
      ST_INIT: begin
        cnt_next = cnt + 1'b1;
        if (cnt == LAST_ROW) begin
          state_next     = ST_RUN;
          init_done_next = 1'b1;
        end
      end
      ST_RUN:  init_done_next = 1'b1;
      default: state_next = ST_RUN;
    endcase
  end

  // Response stage holds while stalled; a consume with no new accept empties it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_wren  <= 1'b0;
      rsp_bank  <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_wren  <= bus.req_wren;
      rsp_bank  <= bank_sel;
    end else if (bus.rsp_ready) begin
      rsp_valid <= 1'b0;
      rsp_wren  <= 1'b0;
    end
  end

  generate
    for (genvar b = 0; b < 2**SEL_W; b++) begin : g_bank
      if (b < BANK_NUM) begin : g_real
        logic [DATA_W-1:0] mem [ROWS];
        logic [DATA_W-1:0] rd_q;
        logic [MASK_W-1:0] we;
        logic [ROW_W-1:0]  waddr;
        logic [DATA_W-1:0] wdata;
        logic              re;

        always_comb begin
          we    = '0;
          waddr = row;
          wdata = bus.req_data;
          re    = 1'b0;
          if (rst_n) begin
            if (state == ST_INIT) begin
              we    = '1;
              waddr = cnt;
              wdata = INIT_VAL;
            end else if (accept && (bank_sel == SEL_W'(b))) begin
              if (bus.req_wren) we = bus.req_mask;
              else              re = 1'b1;
            end
          end
        end

        // The read register only moves on an enabled read, so a stalled response stays intact.
        always_ff @(posedge clk) begin
          for (int k = 0; k < MASK_W; k++) begin
            if (we[k]) mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
          end
          if (re) rd_q <= mem[row];
        end

        assign rd_all[b] = rd_q;
      end else begin : g_pad
        assign rd_all[b] = '0;
      end
    end
  endgenerate

  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_wren  = rsp_wren;
  assign bus.rsp_data  = (rsp_valid & ~rsp_wren) ? rd_all[rsp_bank] : '0;
  assign bus.init_done = init_done;
endmodule
